// File: rtl/ext_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// ext_mem_arbiter_if
//
// IOb-style native memory bus: one request channel (avalid/addr/wdata/wstrb)
// and one response channel (ready/rvalid/rdata).
//
// Modports:
//   master : the side that issues requests (a cache back-end, or the arbiter
//            when it faces external memory).
//            out avalid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]
//            in  ready, rvalid, rdata[DATA_W]
//   slave  : the side that accepts requests (the arbiter facing a cache, or
//            the external memory bridge).
//            in  avalid, addr, wdata, wstrb
//            out ready, rvalid, rdata
//
// A request is accepted on avalid & ready. A write is a request with a
// non-zero wstrb and needs no response; a read (wstrb == 0) is answered by a
// later one-cycle rvalid pulse carrying rdata.
// ----------------------------------------------------------------------------
interface ext_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  avalid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output avalid,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  avalid,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/ext_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ext_mem_arbiter
//
// Shares the single external-memory IOb port between two cache back-ends
// (m0 = instruction cache, m1 = data cache). One master owns the port at a
// time; ownership is decided in IDLE, is locked for the whole transaction,
// and read responses are steered to the owner only.
//
// Ports:
//   clk_i    in   system clock
//   cke_i    in   clock enable; when low, state/owner/last hold
//   arst_i   in   asynchronous active-high reset
//   m0       slave modport  master 0 (instruction) request/response
//   m1       slave modport  master 1 (data) request/response
//   s        master modport request/response towards external memory
//   grant_o  out  one-hot current owner, 2'b00 while idle
//
// Transaction flow:
//   IDLE -> FWD  a request was seen (grant is registered, so the request is
//                forwarded one cycle after it is first seen)
//   FWD  -> IDLE write handshake, or the owner withdrew avalid
//   FWD  -> RD   read handshake
//   RD   -> IDLE rvalid from memory
// ----------------------------------------------------------------------------
module ext_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    ext_mem_arbiter_if.slave      m0,
    ext_mem_arbiter_if.slave      m1,
    ext_mem_arbiter_if.master     s,
    output logic [1:0]            grant_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] RD   = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                owner;
    logic                owner_nxt;
    logic                last;
    logic                last_nxt;

    logic                in_fwd;
    logic                in_rd;
    logic                busy;
    logic                pick;
    logic                own_avalid;
    logic [DATA_W/8-1:0] own_wstrb;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_wstrb;
    logic                sel_m1;

    assign in_fwd = (state == FWD);
    assign in_rd  = (state == RD);
    assign busy   = in_fwd | in_rd;

    // Round-robin choice: on a tie the master that was not served last wins;
    // otherwise whichever master is requesting (m1 only if m0 is not).
    assign pick = (m0.avalid && m1.avalid) ? ~last : m1.avalid;

    assign own_avalid = owner ? m1.avalid : m0.avalid;
    assign own_wstrb  = owner ? m1.wstrb  : m0.wstrb;

    // The request mux defaults to master 0 whenever no transaction is open,
    // so the address/data lines are stable and predictable while idle.
    assign sel_m1    = busy & owner;
    assign sel_addr  = sel_m1 ? m1.addr  : m0.addr;
    assign sel_wdata = sel_m1 ? m1.wdata : m0.wdata;
    assign sel_wstrb = sel_m1 ? m1.wstrb : m0.wstrb;

    // ------------------------------------------------------------------
    // Request path towards external memory
    // ------------------------------------------------------------------
    assign s.avalid = in_fwd & own_avalid;
    assign s.addr   = sel_addr;
    assign s.wdata  = sel_wdata;
    assign s.wstrb  = sel_wstrb;

    // ------------------------------------------------------------------
    // Response path back to the masters
    // ------------------------------------------------------------------
    assign m0.ready  = in_fwd & ~owner & s.ready;
    assign m1.ready  = in_fwd &  owner & s.ready;

    // rvalid only reaches the owner and only in RD, so a response that
    // arrives after a reset (state forced to IDLE) is silently dropped.
    assign m0.rvalid = in_rd & ~owner & s.rvalid;
    assign m1.rvalid = in_rd &  owner & s.rvalid;

    // Read data is broadcast unqualified; rvalid is the only qualifier.
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;

    assign grant_o = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0.avalid || m1.avalid) begin
                    owner_nxt = pick;
                    state_nxt = FWD;
                end
            end
            FWD: begin
                if (!own_avalid) begin
                    // Owner gave up before the handshake: release the port
                    // and count it as served so the other master gets a turn.
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end else if (s.ready) begin
                    if (|own_wstrb) begin
                        last_nxt  = owner;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                if (s.rvalid) begin
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // last resets to 1 so that master 0 wins the very first tie.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else if (cke_i) begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ext_mem_arbiter
//
// Directed bench for ext_mem_arbiter. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled 1 time unit later; the slave side of
// external memory is played by hand in each scenario.
// ----------------------------------------------------------------------------
module tb_ext_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic       clk;
    logic       cke;
    logic       arst;
    logic [1:0] grant;

    int checks;
    int failures;

    ext_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    ext_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
    ext_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

    ext_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i   (clk),
        .cke_i   (cke),
        .arst_i  (arst),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .grant_o (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick();
        tick();
        arst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cke  = 1'b1;
        arst = 1'b1;
        m0_bus.avalid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        m1_bus.avalid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        s_bus.ready = 1'b0; s_bus.rvalid = 1'b0; s_bus.rdata = '0;

        // ---------------- reset state ----------------
        do_reset();
        s_bus.ready  = 1'b1;
        s_bus.rvalid = 1'b1;
        s_bus.rdata  = 32'h0BAD_0BAD;
        #1;
        chk("rst_grant",    grant,            2'b00);
        chk("rst_s_avalid", s_bus.avalid,     1'b0);
        chk("rst_m0_ready", m0_bus.ready,     1'b0);
        chk("rst_m1_ready", m1_bus.ready,     1'b0);
        chk("rst_m0_rvld",  m0_bus.rvalid,    1'b0);
        chk("rst_m1_rvld",  m1_bus.rvalid,    1'b0);
        chk("idle_rdata_bcast", m1_bus.rdata, 32'h0BAD_0BAD);

        // ---------------- single read by m0 ----------------
        tick();
        s_bus.rvalid  = 1'b0;
        m0_bus.avalid = 1'b1; m0_bus.addr = 32'h100; m0_bus.wstrb = 4'h0;
        m1_bus.addr   = 32'h999; m1_bus.wdata = 32'h5555_AAAA;
        #1;
        chk("rd_req_cycle_avalid", s_bus.avalid, 1'b0);
        chk("rd_idle_addr_m0",     s_bus.addr,   32'h100);
        tick();
        chk("rd_fwd_avalid", s_bus.avalid, 1'b1);
        chk("rd_fwd_addr",   s_bus.addr,   32'h100);
        chk("rd_fwd_grant",  grant,        2'b01);
        chk("rd_fwd_m0rdy",  m0_bus.ready, 1'b1);
        chk("rd_fwd_m1rdy",  m1_bus.ready, 1'b0);
        tick();
        m0_bus.avalid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rd_wait_grant",  grant,         2'b01);
            chk("rd_wait_avalid", s_bus.avalid,  1'b0);
            chk("rd_wait_m0rvld", m0_bus.rvalid, 1'b0);
            tick();
        end
        s_bus.rvalid = 1'b1; s_bus.rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_resp_m0rvld", m0_bus.rvalid, 1'b1);
        chk("rd_resp_m0data", m0_bus.rdata,  32'hDEAD_BEEF);
        chk("rd_resp_m1rvld", m1_bus.rvalid, 1'b0);
        chk("rd_resp_grant",  grant,         2'b01);
        tick();
        s_bus.rvalid = 1'b0;
        #1;
        chk("rd_done_grant", grant, 2'b00);

        // ---------------- simultaneous requests, alternating order ----------------
        do_reset();
        m0_bus.avalid = 1'b1; m0_bus.addr = 32'h200; m0_bus.wstrb = 4'h0;
        m1_bus.avalid = 1'b1; m1_bus.addr = 32'h300; m1_bus.wstrb = 4'h0;
        s_bus.ready = 1'b1; s_bus.rvalid = 1'b0;
        #1;
        chk("rr_idle_grant", grant, 2'b00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_fwd_grant", grant,      (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_fwd_addr",  s_bus.addr, (i % 2 == 0) ? 32'h200 : 32'h300);
            chk("rr_fwd_other_rdy", (i % 2 == 0) ? m1_bus.ready : m0_bus.ready, 1'b0);
            tick();
            s_bus.rvalid = 1'b1; s_bus.rdata = 32'h1000 + i;
            #1;
            chk("rr_owner_rvld", (i % 2 == 0) ? m0_bus.rvalid : m1_bus.rvalid, 1'b1);
            chk("rr_other_rvld", (i % 2 == 0) ? m1_bus.rvalid : m0_bus.rvalid, 1'b0);
            tick();
            s_bus.rvalid = 1'b0;
            #1;
            chk("rr_idle_between", grant, 2'b00);
        end

        // ---------------- m1 write (slow ready), m0 read pending ----------------
        m0_bus.avalid = 1'b0;
        m1_bus.avalid = 1'b1; m1_bus.addr = 32'h400; m1_bus.wdata = 32'hA5A5_A5A5; m1_bus.wstrb = 4'hF;
        s_bus.ready = 1'b0;
        tick();
        m0_bus.avalid = 1'b1; m0_bus.addr = 32'h500; m0_bus.wstrb = 4'h0;
        #1;
        chk("wr_fwd_grant", grant,        2'b10);
        chk("wr_fwd_avalid", s_bus.avalid, 1'b1);
        chk("wr_fwd_wdata", s_bus.wdata,  32'hA5A5_A5A5);
        chk("wr_fwd_wstrb", s_bus.wstrb,  4'hF);
        chk("wr_fwd_addr",  s_bus.addr,   32'h400);
        for (int i = 0; i < 4; i++) begin
            chk("wr_stall_m1rdy", m1_bus.ready, 1'b0);
            chk("wr_stall_grant", grant,        2'b10);
            tick();
        end
        s_bus.ready = 1'b1;
        #1;
        chk("wr_hs_m1rdy", m1_bus.ready, 1'b1);
        chk("wr_hs_m0rdy", m0_bus.ready, 1'b0);
        tick();
        m1_bus.avalid = 1'b0;
        #1;
        chk("wr_no_rd_grant", grant, 2'b00);
        tick();
        chk("wr_next_avalid", s_bus.avalid, 1'b1);
        chk("wr_next_addr",   s_bus.addr,   32'h500);
        chk("wr_next_grant",  grant,        2'b01);
        tick();
        m0_bus.avalid = 1'b0;
        s_bus.rvalid = 1'b1; s_bus.rdata = 32'h1234_5678;
        #1;
        chk("wr_next_m0rvld", m0_bus.rvalid, 1'b1);
        chk("wr_next_m1rvld", m1_bus.rvalid, 1'b0);
        tick();
        s_bus.rvalid = 1'b0;

        // ---------------- response isolation during m1 read ----------------
        m1_bus.avalid = 1'b1; m1_bus.addr = 32'h600; m1_bus.wstrb = 4'h0;
        m0_bus.avalid = 1'b1; m0_bus.addr = 32'h700; m0_bus.wstrb = 4'h0;
        tick();
        chk("iso_fwd_grant", grant,        2'b10);
        chk("iso_fwd_addr",  s_bus.addr,   32'h600);
        chk("iso_fwd_m0rdy", m0_bus.ready, 1'b0);
        chk("iso_fwd_m1rdy", m1_bus.ready, 1'b1);
        tick();
        m1_bus.avalid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("iso_rd_m0rdy",  m0_bus.ready, 1'b0);
            chk("iso_rd_addr",   s_bus.addr,   32'h600);
            chk("iso_rd_avalid", s_bus.avalid, 1'b0);
            tick();
        end
        s_bus.rvalid = 1'b1; s_bus.rdata = 32'hCAFE_F00D;
        #1;
        chk("iso_m1rvld", m1_bus.rvalid, 1'b1);
        chk("iso_m1data", m1_bus.rdata,  32'hCAFE_F00D);
        chk("iso_m0rvld", m0_bus.rvalid, 1'b0);
        tick();
        s_bus.rvalid = 1'b0;
        #1;
        chk("iso_idle_grant", grant, 2'b00);
        tick();
        chk("iso_m0_grant", grant,        2'b01);
        chk("iso_m0_addr",  s_bus.addr,   32'h700);
        chk("iso_m0_rdy",   m0_bus.ready, 1'b1);

        // ---------------- reset in the middle of a read ----------------
        tick();
        chk("rstrd_in_rd_grant", grant, 2'b01);
        arst = 1'b1;
        m0_bus.avalid = 1'b0;
        #1;
        chk("rstrd_async_grant", grant, 2'b00);
        tick();
        arst = 1'b0;
        s_bus.rvalid = 1'b1; s_bus.rdata = 32'hFACE_FACE;
        #1;
        chk("rstrd_m0rvld", m0_bus.rvalid, 1'b0);
        chk("rstrd_m1rvld", m1_bus.rvalid, 1'b0);
        chk("rstrd_grant",  grant,         2'b00);
        tick();
        s_bus.rvalid = 1'b0;
        #1;
        chk("rstrd_stays_idle", grant, 2'b00);

        // ---------------- clock enable ----------------
        cke = 1'b0;
        s_bus.ready = 1'b0;
        m0_bus.avalid = 1'b1; m0_bus.addr = 32'h800; m0_bus.wdata = 32'h1122_3344; m0_bus.wstrb = 4'h3;
        tick();
        chk("cke_idle_hold_grant",  grant,        2'b00);
        chk("cke_idle_hold_avalid", s_bus.avalid, 1'b0);
        cke = 1'b1;
        tick();
        chk("cke_fwd_grant", grant,       2'b01);
        chk("cke_fwd_wdata", s_bus.wdata, 32'h1122_3344);
        cke = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("cke_hold_grant",  grant,        2'b01);
            chk("cke_hold_avalid", s_bus.avalid, 1'b1);
        end
        cke = 1'b1;
        s_bus.ready = 1'b1;
        #1;
        chk("cke_hs_m0rdy", m0_bus.ready, 1'b1);
        chk("cke_hs_wstrb", s_bus.wstrb,  4'h3);
        tick();
        m0_bus.avalid = 1'b0;
        #1;
        chk("cke_done_grant", grant, 2'b00);

        // ---------------- owner withdraws before handshake ----------------
        s_bus.ready = 1'b0;
        m1_bus.avalid = 1'b1; m1_bus.addr = 32'h900; m1_bus.wstrb = 4'h0;
        tick();
        chk("abort_fwd_grant", grant, 2'b10);
        m1_bus.avalid = 1'b0;
        #1;
        chk("abort_avalid", s_bus.avalid, 1'b0);
        tick();
        chk("abort_idle_grant", grant, 2'b00);
        m0_bus.avalid = 1'b1; m0_bus.addr = 32'hA00;
        m1_bus.avalid = 1'b1; m1_bus.addr = 32'hB00;
        tick();
        chk("abort_tie_grant", grant,      2'b01);
        chk("abort_tie_addr",  s_bus.addr, 32'hA00);
        m0_bus.avalid = 1'b0;
        m1_bus.avalid = 1'b0;
        tick();
        chk("end_idle_grant", grant, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
